dm_load: RTL and testbench

Load-side companion to the data memory's store path. Sits in the M stage and issues word-aligned read requests to a handshaked data-memory read port. It selects the byte, halfword or word addressed by the load and sign- or zero-extends it. It returns the result to the W stage with a one-cycle valid pulse, stalling the pipeline while the read is outstanding. It also flags misaligned loads (AdEL) and read timeouts.

---
 rtl/dm_load.sv | 136 +++++++++++++
 tb/tb_dm_load.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dm_load.sv
// dm_load: load path of the M stage. Issues a word-aligned read, then selects
// and extends the addressed byte, halfword or word. It stalls the pipeline
// while the read is outstanding, flags misaligned loads, and abandons reads
// that exceed TIMEOUT cycles.
//
// state | meaning
// IDLE  | no read outstanding; accepts ld_en
// WAIT  | rd_req high, waiting for rd_ack or timeout
// DONE  | ld_valid pulse; the load moves on to W

module dm_load #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_en,
   input  logic [31:0] memaddr,
   input  logic [2:0]  dmoctr,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ack,
   input  logic [31:0] rd_data,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        adel,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [7:0] TC = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [1:0]  off;
   logic [2:0]  typ;
   logic        misaligned;
   logic        accept;
   logic        timeout;
   logic [31:0] ext;

   // misalignment check on the incoming address; codes 5-7 behave as lw
   always_comb begin
      misaligned = 1'b0;
      case (dmoctr)
         3'd1, 3'd2: misaligned = memaddr[0];
         3'd3, 3'd4: misaligned = 1'b0;
         default:    misaligned = |memaddr[1:0];
      endcase
   end

   assign accept  = (state == IDLE) && ld_en && !misaligned;
   assign timeout = (state == WAIT) && !rd_ack && (cnt == TC);
   assign stall   = accept || (state == WAIT);

   // select and extend the addressed part of the returned word
   always_comb begin
      logic [15:0] half;
      logic [7:0]  byte_v;
      half   = off[1] ? rd_data[31:16] : rd_data[15:0];
      byte_v = rd_data[8*off +: 8];
      case (typ)
         3'd1:    ext = {{16{half[15]}}, half};
         3'd2:    ext = {16'h0000, half};
         3'd3:    ext = {{24{byte_v[7]}}, byte_v};
         3'd4:    ext = {24'h000000, byte_v};
         default: ext = rd_data;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; ld_en in DONE still belongs to the finished load
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: if (rd_ack || timeout) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // request, result and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_req   <= 1'b0;
         rd_addr  <= 32'h0;
         ld_valid <= 1'b0;
         ld_data  <= 32'h0;
         adel     <= 1'b0;
         bus_err  <= 1'b0;
         cnt      <= 8'h0;
         off      <= 2'b00;
         typ      <= 3'd0;
      end else begin
         ld_valid <= 1'b0;
         adel     <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  off     <= memaddr[1:0];
                  typ     <= dmoctr;
                  rd_addr <= {memaddr[31:2], 2'b00};
                  rd_req  <= 1'b1;
                  cnt     <= 8'h0;
               end else if (ld_en) begin
                  adel <= 1'b1;
               end
            end
            WAIT: begin
               if (rd_ack) begin
                  ld_data  <= ext;
                  ld_valid <= 1'b1;
                  rd_req   <= 1'b0;
               end else if (timeout) begin
                  ld_data  <= 32'h0;
                  ld_valid <= 1'b1;
                  bus_err  <= 1'b1;
                  rd_req   <= 1'b0;
               end else begin
                  cnt <= cnt + 8'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_load.sv
// Directed bench for dm_load with a scoreboard of expected load results.
module tb_dm_load;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_en;
   logic [31:0] memaddr;
   logic [2:0]  dmoctr;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        stall;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        adel;
   logic        bus_err;

   dm_load #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .memaddr(memaddr), .dmoctr(dmoctr),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .adel(adel),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        berr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
   endtask

   // monitor: every ld_valid pops one expected result
   always @(negedge clk) begin
      if (!rst && ld_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ld_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ld_data", ld_data, e.data);
            check("bus_err", {31'h0, bus_err}, {31'h0, e.berr});
            check("ld_valid_cycle", cyc, e.cyc);
         end
      end else if (!rst && bus_err) begin
         check("bus_err_without_valid", 32'd1, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ack_cyc = 0 means never acknowledge; hold keeps ld_en high in DONE
   task automatic do_load(input logic [31:0] a, input logic [2:0] op, input int ack_cyc,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_b,
                          input logic hold);
      int c0, last;
      exp_t e;
      c0 = cyc;
      last = (ack_cyc > 0 && ack_cyc <= TO) ? ack_cyc : TO;
      e.data = exp_d; e.berr = exp_b; e.cyc = c0 + last + 1;
      exp_q.push_back(e);
      ld_en = 1'b1; memaddr = a; dmoctr = op; rd_ack = 1'b0; rd_data = d;
      @(negedge clk);
      check("stall_c0", {31'h0, stall}, 32'd1);
      tick();
      ld_en = 1'b0;
      for (int i = 1; i <= last; i++) begin
         rd_ack = (i == ack_cyc);
         @(negedge clk);
         check("stall_wait", {31'h0, stall}, 32'd1);
         if (i == 1) begin
            check("rd_req", {31'h0, rd_req}, 32'd1);
            check("rd_addr", rd_addr, {a[31:2], 2'b00});
         end
         tick();
      end
      rd_ack = 1'b0;
      ld_en = hold;
      @(negedge clk);
      check("stall_done", {31'h0, stall}, 32'd0);
      check("rd_req_done", {31'h0, rd_req}, 32'd0);
      tick();
      ld_en = 1'b0;
   endtask

   task automatic do_misaligned(input logic [31:0] a, input logic [2:0] op);
      ld_en = 1'b1; memaddr = a; dmoctr = op;
      @(negedge clk);
      check("mis_stall", {31'h0, stall}, 32'd0);
      tick();
      ld_en = 1'b0;
      @(negedge clk);
      check("adel_pulse", {31'h0, adel}, 32'd1);
      check("mis_rd_req", {31'h0, rd_req}, 32'd0);
      tick();
      @(negedge clk);
      check("adel_clear", {31'h0, adel}, 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ld_en = 1'b0; memaddr = 32'h0; dmoctr = 3'd0;
      rd_ack = 1'b0; rd_data = 32'h0;
      tick(); tick();
      check("rst_rd_req", {31'h0, rd_req}, 32'd0);
      check("rst_rd_addr", rd_addr, 32'h0);
      check("rst_ld_data", ld_data, 32'h0);
      check("rst_ld_valid", {31'h0, ld_valid}, 32'd0);
      check("rst_stall", {31'h0, stall}, 32'd0);
      rst = 1'b0;
      tick();

      // lb signed, fast ack
      do_load(32'h0000_1003, 3'd3, 1, 32'h80AB_CDEF, 32'hFFFF_FF80, 1'b0, 1'b0);
      // lhu upper half, ack in cycle 4 (also the timeout cycle: ack wins)
      do_load(32'h0000_0042, 3'd2, 4, 32'h9234_5678, 32'h0000_9234, 1'b0, 1'b0);
      // misaligned lw and lh
      do_misaligned(32'h0000_0006, 3'd0);
      do_misaligned(32'h0000_0001, 3'd1);
      // timeout with no ack
      do_load(32'h0000_0100, 3'd0, 0, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
      // ack in the timeout cycle, lh upper signed
      do_load(32'h0000_0102, 3'd1, TO, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 1'b0);
      // assorted extraction cases
      do_load(32'h0000_0013, 3'd4, 2, 32'hA500_0000, 32'h0000_00A5, 1'b0, 1'b0);
      do_load(32'h0000_0000, 3'd1, 1, 32'h0000_8765, 32'hFFFF_8765, 1'b0, 1'b0);
      do_load(32'h0000_0004, 3'd7, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);
      // back-to-back, ld_en held during the first DONE
      do_load(32'h0000_0010, 3'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
      do_load(32'h0000_0011, 3'd3, 1, 32'h1234_5678, 32'h0000_0056, 1'b0, 1'b0);

      // reset during WAIT, late ack ignored
      ld_en = 1'b1; memaddr = 32'h0000_0020; dmoctr = 3'd0; rd_data = 32'h5555_AAAA;
      tick();
      ld_en = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstw_rd_req", {31'h0, rd_req}, 32'd0);
      check("rstw_stall", {31'h0, stall}, 32'd0);
      tick();
      rd_ack = 1'b1;
      @(negedge clk);
      check("rstw_ack_stall", {31'h0, stall}, 32'd0);
      tick();
      rd_ack = 1'b0;
      @(negedge clk);
      check("rstw_ld_valid", {31'h0, ld_valid}, 32'd0);
      check("rstw_ld_data", ld_data, 32'h0);
      check("rstw_rd_addr", rd_addr, 32'h0);
      check("rstw_bus_err", {31'h0, bus_err}, 32'd0);
      tick(); tick();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
